uart_transmitter: RTL and testbench

Serial transmit half of the UART: accepts a parallel byte on a one-cycle start strobe and shifts it out on `tx` as a standard asynchronous frame (start bit, DATA_BITS data bits LSB-first, optional parity bit, stop bit(s)). It is paced by the same 16× oversampling `s_tick` enable that drives the receiver, coming from the shared baud-rate generator. It sits between the TX FIFO/host interface and the `tx` pad.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_transmitter_if.sv | 14 +
 rtl/uart_transmitter.sv | 145 ++++++++++++++
 tb/tb_uart_transmitter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling ratio and frame defaults
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE         = 16;
    localparam int DEF_DATA_BITS      = 8;
    localparam int DEF_STOP_BITS_TICK = 16;

endpackage

// File: rtl/uart_transmitter_if.sv
// Host-side handshake of the UART transmitter: start strobe, byte, status and
// the serial line. The host drives through master, the transmitter is slave.
interface uart_transmitter_if;

    logic       tx_start;
    logic [7:0] din;
    logic       tx_done_tick;
    logic       tx_busy;
    logic       tx;

    modport master (output tx_start, din, input  tx_done_tick, tx_busy, tx);
    modport slave  (input  tx_start, din, output tx_done_tick, tx_busy, tx);

endinterface

// File: rtl/uart_transmitter.sv
// UART transmit FSM paced by the 16x s_tick enable; sends start, data LSB-first,
// optional even parity (UART_PARITY_EN) and STOP_BITS_TICK ticks of stop.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS      = DEF_DATA_BITS,
    parameter int STOP_BITS_TICK = DEF_STOP_BITS_TICK
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    uart_transmitter_if.slave   bus
);

    localparam logic [4:0] TICK_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(STOP_BITS_TICK - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [7:0] DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);

    uart_state_e r_state, w_state_nx;
    logic [4:0]  r_s, w_s_nx;
    logic [2:0]  r_n, w_n_nx;
    logic [7:0]  r_shift, w_shift_nx;
    logic        r_tx, w_tx_nx;
    logic        w_done;
`ifdef UART_PARITY_EN
    logic        r_parity, w_parity_nx;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_s      <= '0;
            r_n      <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef UART_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_s      <= w_s_nx;
            r_n      <= w_n_nx;
            r_shift  <= w_shift_nx;
            r_tx     <= w_tx_nx;
`ifdef UART_PARITY_EN
            r_parity <= w_parity_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_s_nx      = r_s;
        w_n_nx      = r_n;
        w_shift_nx  = r_shift;
        w_done      = 1'b0;
`ifdef UART_PARITY_EN
        w_parity_nx = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (bus.tx_start) begin
                    w_state_nx  = START;
                    w_s_nx      = '0;
                    w_n_nx      = '0;
                    w_shift_nx  = bus.din & DATA_MASK;
`ifdef UART_PARITY_EN
                    w_parity_nx = ^(bus.din & DATA_MASK);
`endif
                end
            end
            START: begin
                if (s_tick) begin
                    if (r_s == TICK_LAST) begin
                        w_s_nx     = '0;
                        w_state_nx = DATA;
                    end else begin
                        w_s_nx = r_s + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (r_s == TICK_LAST) begin
                        w_s_nx     = '0;
                        w_shift_nx = r_shift >> 1;
                        if (r_n == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            w_state_nx = PARITY;
`else
                            w_state_nx = STOP;
`endif
                        end else begin
                            w_n_nx = r_n + 3'd1;
                        end
                    end else begin
                        w_s_nx = r_s + 5'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (r_s == TICK_LAST) begin
                        w_s_nx     = '0;
                        w_state_nx = STOP;
                    end else begin
                        w_s_nx = r_s + 5'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (r_s == STOP_LAST) begin
                        w_state_nx = IDLE;
                        w_done     = 1'b1;
                    end else begin
                        w_s_nx = r_s + 5'd1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // tx is registered, so it is derived from where the FSM is heading next
    always_comb begin
        w_tx_nx = 1'b1;
        case (w_state_nx)
            START:   w_tx_nx = 1'b0;
            DATA:    w_tx_nx = w_shift_nx[0];
`ifdef UART_PARITY_EN
            PARITY:  w_tx_nx = w_parity_nx;
`endif
            default: w_tx_nx = 1'b1;
        endcase
    end

    assign bus.tx           = r_tx;
    assign bus.tx_busy      = (r_state != IDLE);
    assign bus.tx_done_tick = w_done;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: two instances (1 and 2 stop bits),
// expected frames queued by stimulus, checked per bit by a tick-counting monitor.
module tb_uart_transmitter;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         abort;
    } exp_t;

`ifdef UART_PARITY_EN
    localparam int PAR_T = 16;
`else
    localparam int PAR_T = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       st [2];
    logic [7:0] dd [2];
    logic       w_tx [2];
    logic       w_busy [2];
    logic       w_done [2];

    int checks = 0;
    int errors = 0;
    int tdiv = 0;

    always #5 clk = ~clk;

    // s_tick every 4 clocks, changed just after the rising edge
    always @(posedge clk) begin
        #2;
        tdiv   = (tdiv + 1) % 4;
        s_tick = (tdiv == 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(exp_t e, int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return e.data[p-1];
`ifdef UART_PARITY_EN
        if (p == 9) return e.par;
`endif
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int STOPT = (g == 0) ? 16 : 32;
        localparam int FR    = 16 + 16 * 8 + PAR_T + STOPT;

        uart_transmitter_if bus();
        assign bus.tx_start = st[g];
        assign bus.din      = dd[g];
        assign w_tx[g]      = bus.tx;
        assign w_busy[g]    = bus.tx_busy;
        assign w_done[g]    = bus.tx_done_tick;

        uart_transmitter #(.DATA_BITS(8), .STOP_BITS_TICK(STOPT)) dut (
            .clk    (clk),
            .reset  (reset),
            .s_tick (s_tick),
            .bus    (bus)
        );

        exp_t q[$];
        exp_t cur;
        bit   in_fr = 1'b0;
        int   tcnt  = 0;
        int   ccnt  = 0;

        always @(negedge clk) begin
            if (!in_fr && w_busy[g]) begin
                if (q.size() == 0) begin
                    chk($sformatf("i%0d_unexpected_frame", g), 1, 0);
                    cur = '{data: 8'h00, par: 1'b0, abort: 1'b0};
                end else begin
                    cur = q.pop_front();
                end
                in_fr = 1'b1;
                tcnt  = 0;
                ccnt  = 0;
            end
            if (in_fr) begin
                ccnt++;
                if (!w_busy[g]) begin
                    chk($sformatf("i%0d_frame_abort_%0h", g, cur.data), 32'(cur.abort), 1);
                    in_fr = 1'b0;
                end else if (s_tick) begin
                    if (tcnt % 16 == 8)
                        chk($sformatf("i%0d_bit%0d_%0h", g, tcnt / 16, cur.data),
                            32'(w_tx[g]), 32'(exp_bit(cur, tcnt / 16)));
                    tcnt++;
                    if (w_done[g]) begin
                        chk($sformatf("i%0d_frame_ticks_%0h", g, cur.data), tcnt, FR);
                        chk($sformatf("i%0d_done_unaborted_%0h", g, cur.data), 32'(cur.abort), 0);
                        chk($sformatf("i%0d_done_clks_%0h", g, cur.data),
                            32'(ccnt >= FR * 4 - 3 && ccnt <= FR * 4), 1);
                        in_fr = 1'b0;
                    end
                end else if (w_done[g]) begin
                    chk($sformatf("i%0d_done_without_tick", g), 1, 0);
                end
            end else if (w_done[g]) begin
                chk($sformatf("i%0d_stray_done", g), 1, 0);
            end
        end
    end

    task automatic push(input int inst, input logic [7:0] d, input logic par, input bit ab);
        exp_t e;
        e = '{data: d, par: par, abort: ab};
        if (inst == 0) gi[0].q.push_back(e);
        else           gi[1].q.push_back(e);
    endtask

    // Queue the expectation, pulse tx_start, and check the 1-cycle start latency
    task automatic send(input int inst, input logic [7:0] d, input logic par, input bit ab);
        push(inst, d, par, ab);
        @(posedge clk); #1;
        st[inst] = 1'b1;
        dd[inst] = d;
        @(posedge clk); #1;
        st[inst] = 1'b0;
        chk($sformatf("i%0d_start_tx_low_%0h", inst, d), 32'(w_tx[inst]), 0);
        chk($sformatf("i%0d_start_busy_%0h", inst, d), 32'(w_busy[inst]), 1);
    endtask

    // Returns at the falling edge of the cycle in which tx_done_tick is high
    task automatic wait_done(input int inst, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!w_done[inst] && k < budget);
        if (!w_done[inst]) chk($sformatf("i%0d_wait_done_timeout", inst), 1, 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        st[0] = 1'b0; st[1] = 1'b0;
        dd[0] = 8'h00; dd[1] = 8'h00;
        reset = 1'b1;
        idle_cycles(3);
        chk("reset_tx", 32'(w_tx[0]), 1);
        chk("reset_busy", 32'(w_busy[0]), 0);
        chk("reset_done", 32'(w_done[0]), 0);
        chk("reset_tx_i1", 32'(w_tx[1]), 1);
        reset = 1'b0;
        idle_cycles(5);
        chk("idle_tx", 32'(w_tx[0]), 1);

        // 0x55 with a 0xFF start request in mid-DATA that must be ignored
        send(0, 8'h55, 1'b0, 1'b0);
        idle_cycles(300);
        st[0] = 1'b1; dd[0] = 8'hFF;
        @(posedge clk); #1;
        st[0] = 1'b0;
        chk("mid_data_busy", 32'(w_busy[0]), 1);
        wait_done(0, 2000);
        // start on the tx_done_tick cycle is ignored
        st[0] = 1'b1; dd[0] = 8'h3C;
        @(posedge clk); #1;
        st[0] = 1'b0;
        chk("start_on_done_busy", 32'(w_busy[0]), 0);
        chk("start_on_done_tx", 32'(w_tx[0]), 1);
        idle_cycles(4);

        // back-to-back: 0x0F then 0xA3 started the cycle after tx_done_tick
        send(0, 8'h0F, 1'b0, 1'b0);
        wait_done(0, 2000);
        send(0, 8'hA3, 1'b0, 1'b0);
        wait_done(0, 2000);
        idle_cycles(4);

        // reset during data bit 3, then a clean full frame
        send(0, 8'h55, 1'b0, 1'b1);
        idle_cycles(260);
        chk("pre_reset_busy", 32'(w_busy[0]), 1);
        reset = 1'b1;
        #1;
        chk("midframe_reset_tx", 32'(w_tx[0]), 1);
        chk("midframe_reset_busy", 32'(w_busy[0]), 0);
        chk("midframe_reset_done", 32'(w_done[0]), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(3);
        send(0, 8'hC6, 1'b0, 1'b0);
        wait_done(0, 2000);

        // two stop bits
        send(1, 8'h00, 1'b0, 1'b0);
        wait_done(1, 2000);
        send(1, 8'h81, 1'b0, 1'b0);
        wait_done(1, 2000);

`ifdef UART_PARITY_EN
        send(0, 8'h07, 1'b1, 1'b0);
        wait_done(0, 2000);
        send(0, 8'h03, 1'b0, 1'b0);
        wait_done(0, 2000);
`endif

        begin
            int k;
            k = 0;
            while ((gi[0].q.size() != 0 || gi[0].in_fr || gi[1].q.size() != 0 || gi[1].in_fr)
                   && k < 3000) begin
                @(negedge clk);
                k++;
            end
            if (k >= 3000) chk("drain_timeout", 1, 0);
        end
        idle_cycles(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
